// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch front end.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_MISALIGNED = 2'd1,
        EXC_ACCESS     = 2'd2
    } fetch_exc_e;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        fetch_exc_e  exc;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR, exc: EXC_NONE};

endpackage

// File: rtl/rv32i_if_stage_skid_buf.sv
// One-entry holding register that catches the in-flight fetch response while decode stalls.
module if_skid_buf
    import rv32i_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IF_ID_RESET;
        end else if (clear || drain) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage: PC sequencing, 1-cycle imem pairing, stall skid,
// redirect flush and fetch-fault reporting into the IF/ID register.
module rv32i_if_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          DEPTH_WORDS = 2048,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_stall,
    input  logic          ex_redirect,
    input  logic [31:0]   ex_redirect_pc,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          if_id_valid,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_instr,
    output logic [1:0]    if_id_exc
);

    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    logic [31:0]  pc_q;
    logic         resp_v;
    logic [31:0]  resp_pc;
    fetch_exc_e   resp_exc;
    fetch_state_e state_q;
    if_id_t       if_id_q;
    if_id_t       skid_q;

    fetch_exc_e   fault_exc;
    logic         fetch_ok;
    logic         fault_issue;
    if_id_t       resp;
    logic         skid_load;
    logic         skid_drain;

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        fault_exc = EXC_NONE;
        if (pc_q[1:0] != 2'b00)
            fault_exc = EXC_MISALIGNED;
        else if ({2'b00, pc_q[31:2]} >= DEPTH_W32)
            fault_exc = EXC_ACCESS;

        fetch_ok    = (state_q == S_RUN) && !id_stall && !ex_redirect;
        imem_en     = fetch_ok && (fault_exc == EXC_NONE);
        fault_issue = fetch_ok && (fault_exc != EXC_NONE);

        // A faulting slot never touched imem, so its word is forced to a NOP.
        resp.valid = resp_v;
        resp.pc    = resp_pc;
        resp.instr = (resp_exc == EXC_NONE) ? imem_rdata : NOP_INSTR;
        resp.exc   = resp_exc;

        skid_load  = !ex_redirect && id_stall && resp_v;
        skid_drain = !ex_redirect && !id_stall && skid_q.valid;
    end

    assign imem_addr = pc_q[AW+1:2];

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (ex_redirect),
        .d     (resp),
        .q     (skid_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            resp_v   <= 1'b0;
            resp_pc  <= 32'h0;
            resp_exc <= EXC_NONE;
            state_q  <= S_RUN;
            if_id_q  <= IF_ID_RESET;
        end else if (ex_redirect) begin
            pc_q          <= ex_redirect_pc;
            resp_v        <= 1'b0;
            state_q       <= S_RUN;
            if_id_q.valid <= 1'b0;
        end else begin
            resp_v   <= imem_en || fault_issue;
            resp_pc  <= pc_q;
            resp_exc <= fault_exc;
            if (imem_en)
                pc_q <= pc_q + 32'd4;
            if (fault_issue)
                state_q <= S_FAULT;
            // Skid holds the older word, so it drains ahead of any live response.
            if (!id_stall) begin
                if (skid_q.valid)
                    if_id_q <= skid_q;
                else if (resp.valid)
                    if_id_q <= resp;
                else
                    if_id_q.valid <= 1'b0;
            end
        end
    end

    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_exc   = if_id_q.exc;

endmodule
